// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//   Shares one block-wide main memory between the instruction cache (I) and
//   the data cache (D). One whole block transaction (read or write-back) is
//   in flight at a time. Simultaneous requests are resolved round-robin, and
//   each cache sees the same busywait handshake a dedicated memory would give.
//
// Ports
//   clock, reset                   clock; asynchronous active-low reset
//   i_read, i_address              I-cache block read request
//   i_readdata, i_busywait         block and stall back to the I-cache
//   d_read, d_write, d_address,    D-cache read / write-back request
//   d_writedata
//   d_readdata, d_busywait         block and stall back to the D-cache
//   m_read, m_write, m_address,    memory request side
//   m_writedata
//   m_readdata, m_busywait         memory response side
//   i_count, d_count               completed transactions per port (saturating)
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int BLK_W  = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [BLK_W-1:0]  i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [BLK_W-1:0]  d_writedata,
    output logic [BLK_W-1:0]  d_readdata,
    output logic              d_busywait,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [BLK_W-1:0]  m_writedata,
    input  logic [BLK_W-1:0]  m_readdata,
    input  logic              m_busywait,
    output logic [CNT_W-1:0]  i_count,
    output logic [CNT_W-1:0]  d_count
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t           state_q;
    logic             started_q;  // memory has shown busy for this grant
    logic             last_q;     // port served last: 0 = I, 1 = D
    logic [CNT_W-1:0] i_cnt_q;
    logic [CNT_W-1:0] d_cnt_q;

    logic i_req, d_req, grant_i, grant_d, done;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    assign grant_i = (state_q == GRANT_I);
    assign grant_d = (state_q == GRANT_D);
    // Memory must have gone busy once before a low busywait means "finished";
    // otherwise the idle-low busywait in the grant cycle would look like done.
    assign done    = started_q & ~m_busywait;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            last_q    <= 1'b0;
            i_cnt_q   <= '0;
            d_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    started_q <= 1'b0;
                    if (i_req && d_req) state_q <= last_q ? GRANT_I : GRANT_D;
                    else if (i_req)     state_q <= GRANT_I;
                    else if (d_req)     state_q <= GRANT_D;
                end
                GRANT_I: begin
                    if (!i_req) begin
                        // abandoned: no credit, round-robin order unchanged
                        state_q   <= RELEASE;
                        started_q <= 1'b0;
                    end else if (done) begin
                        state_q   <= RELEASE;
                        started_q <= 1'b0;
                        last_q    <= 1'b0;
                        if (~&i_cnt_q) i_cnt_q <= i_cnt_q + CNT_W'(1);
                    end else if (m_busywait) begin
                        started_q <= 1'b1;
                    end
                end
                GRANT_D: begin
                    if (!d_req) begin
                        state_q   <= RELEASE;
                        started_q <= 1'b0;
                    end else if (done) begin
                        state_q   <= RELEASE;
                        started_q <= 1'b0;
                        last_q    <= 1'b1;
                        if (~&d_cnt_q) d_cnt_q <= d_cnt_q + CNT_W'(1);
                    end else if (m_busywait) begin
                        started_q <= 1'b1;
                    end
                end
                default: begin  // RELEASE: one cycle with strobes low
                    state_q   <= IDLE;
                    started_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory side is a pure function of the registered grant, so an async
    // reset drops the strobes immediately. Write wins over read on D.
    assign m_read      = grant_i | (grant_d & d_read & ~d_write);
    assign m_write     = grant_d & d_write;
    assign m_address   = grant_i ? i_address : (grant_d ? d_address : '0);
    assign m_writedata = grant_d ? d_writedata : '0;

    assign i_readdata  = grant_i ? m_readdata : '0;
    assign d_readdata  = grant_d ? m_readdata : '0;

    assign i_busywait  = i_req & ~(grant_i & done);
    assign d_busywait  = d_req & ~(grant_d & done);

    assign i_count     = i_cnt_q;
    assign d_count     = d_cnt_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
    localparam int AW = 6;
    localparam int BW = 128;
    localparam int CW = 8;  // narrow counter keeps the saturation run short

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic [BW-1:0] i_readdata;
    logic          i_busywait;
    logic          d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] d_address = '0;
    logic [BW-1:0] d_writedata = '0;
    logic [BW-1:0] d_readdata;
    logic          d_busywait;
    logic          m_read, m_write;
    logic [AW-1:0] m_address;
    logic [BW-1:0] m_writedata;
    logic [BW-1:0] m_readdata = '0;
    logic          m_busywait = 1'b0;
    logic [CW-1:0] i_count, d_count;

    int errors = 0;
    int checks = 0;
    int mem_lat = 4;

    localparam logic [BW-1:0] DATA_A5 = {4{32'hA5A5A5A5}};
    localparam logic [BW-1:0] DATA_12 = {8{16'h1234}};

    cache_mem_arbiter #(.ADDR_W(AW), .BLK_W(BW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata),
        .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_readdata(d_readdata), .d_busywait(d_busywait),
        .m_read(m_read), .m_write(m_write), .m_address(m_address),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_busywait(m_busywait),
        .i_count(i_count), .d_count(d_count)
    );

    always #5 clock = ~clock;

    // Memory model: on first seeing a strobe, busy for mem_lat cycles, then
    // stays not-busy until the strobe drops.
    int  rem = 0;
    bit  mdone = 1'b0;
    always @(posedge clock) begin
        if (!(m_read | m_write)) begin
            rem <= 0; mdone <= 1'b0; m_busywait <= 1'b0;
        end else if (!mdone && rem == 0) begin
            m_busywait <= 1'b1; rem <= mem_lat;
        end else if (rem > 1) begin
            rem <= rem - 1;
        end else if (rem == 1) begin
            rem <= 0; m_busywait <= 1'b0; mdone <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Steps until the selected busywait is low; n = cycles waited, -1 on timeout.
    task automatic wait_bw(input bit sel_d, output int n);
        n = 0;
        while (((sel_d ? d_busywait : i_busywait) == 1'b1) && n < 200) begin
            tick(); n++;
        end
        if (n >= 200) n = -1;
    endtask

    task automatic test_reset();
        i_read = 1'b1;
        #12;
        checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin errors++;
            $display("FAIL rst_strobes: got r=%b w=%b want 0 0", m_read, m_write); end
        checks++; if (i_busywait !== 1'b1 || d_busywait !== 1'b0) begin errors++;
            $display("FAIL rst_busy: got i=%b d=%b want 1 0", i_busywait, d_busywait); end
        checks++; if (i_count !== 8'd0 || d_count !== 8'd0) begin errors++;
            $display("FAIL rst_cnt: got %0d %0d want 0 0", i_count, d_count); end
        checks++; if (m_address !== 6'd0 || i_readdata !== '0 || m_writedata !== '0) begin errors++;
            $display("FAIL rst_data: got addr=%h want 0", m_address); end
        i_read = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_tie();
        int n;
        mem_lat = 2;
        i_read = 1'b1; i_address = 6'd1; d_read = 1'b1; d_address = 6'd2;
        tick();
        checks++; if (m_read !== 1'b1 || m_address !== 6'd2) begin errors++;
            $display("FAIL tie1_first_D: got r=%b addr=%h want 1 02", m_read, m_address); end
        wait_bw(1'b1, n);
        checks++; if (n != 3) begin errors++;
            $display("FAIL tie1_D_latency: got %0d want 3", n); end
        checks++; if (i_busywait !== 1'b1) begin errors++;
            $display("FAIL tie1_I_waits: got %b want 1", i_busywait); end
        tick(); d_read = 1'b0;
        checks++; if (d_count !== 8'd1 || i_busywait !== 1'b1 || m_read !== 1'b0) begin errors++;
            $display("FAIL tie1_release: got dcnt=%0d ibw=%b mr=%b want 1 1 0", d_count, i_busywait, m_read); end
        tick(); tick();
        checks++; if (m_read !== 1'b1 || m_address !== 6'd1) begin errors++;
            $display("FAIL tie1_second_I: got r=%b addr=%h want 1 01", m_read, m_address); end
        wait_bw(1'b0, n);
        tick(); i_read = 1'b0;
        checks++; if (i_count !== 8'd1) begin errors++;
            $display("FAIL tie1_icnt: got %0d want 1", i_count); end
        // lone D makes D the last served, so the next tie goes to I
        d_read = 1'b1; d_address = 6'd3;
        tick(); tick();
        wait_bw(1'b1, n);
        tick(); d_read = 1'b0;
        i_read = 1'b1; d_read = 1'b1; d_address = 6'd2;
        tick(); tick();
        checks++; if (m_read !== 1'b1 || m_address !== 6'd1) begin errors++;
            $display("FAIL tie2_first_I: got r=%b addr=%h want 1 01", m_read, m_address); end
        wait_bw(1'b0, n);
        tick(); i_read = 1'b0;
        tick(); tick();
        checks++; if (m_read !== 1'b1 || m_address !== 6'd2) begin errors++;
            $display("FAIL tie2_second_D: got r=%b addr=%h want 1 02", m_read, m_address); end
        wait_bw(1'b1, n);
        tick(); d_read = 1'b0;
        checks++; if (i_count !== 8'd2 || d_count !== 8'd3) begin errors++;
            $display("FAIL tie2_counts: got %0d %0d want 2 3", i_count, d_count); end
        tick();
    endtask

    task automatic test_i_read();
        int n;
        mem_lat = 4; m_readdata = DATA_A5;
        i_read = 1'b1; i_address = 6'h05;
        tick();
        checks++; if (m_read !== 1'b1 || m_write !== 1'b0 || m_address !== 6'h05) begin errors++;
            $display("FAIL iread_grant: got r=%b w=%b addr=%h want 1 0 05", m_read, m_write, m_address); end
        wait_bw(1'b0, n);
        checks++; if (n != 5) begin errors++;
            $display("FAIL iread_latency: got %0d want 5", n); end
        checks++; if (i_readdata !== DATA_A5 || d_readdata !== '0) begin errors++;
            $display("FAIL iread_data: got %h want %h", i_readdata, DATA_A5); end
        checks++; if (d_busywait !== 1'b0) begin errors++;
            $display("FAIL iread_dbusy: got %b want 0", d_busywait); end
        tick(); i_read = 1'b0;
        checks++; if (i_count !== 8'd3 || m_read !== 1'b0 || i_readdata !== '0) begin errors++;
            $display("FAIL iread_release: got cnt=%0d mr=%b want 3 0", i_count, m_read); end
        tick();
    endtask

    task automatic test_d_write();
        int n;
        mem_lat = 2;
        d_write = 1'b1; d_address = 6'h3F; d_writedata = DATA_12;
        tick();
        checks++; if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 6'h3F) begin errors++;
            $display("FAIL dwr_grant: got w=%b r=%b addr=%h want 1 0 3f", m_write, m_read, m_address); end
        checks++; if (m_writedata !== DATA_12) begin errors++;
            $display("FAIL dwr_data: got %h want %h", m_writedata, DATA_12); end
        wait_bw(1'b1, n);
        checks++; if (n != 3) begin errors++;
            $display("FAIL dwr_latency: got %0d want 3", n); end
        tick(); d_write = 1'b0;
        checks++; if (m_write !== 1'b0 || m_read !== 1'b0 || d_count !== 8'd4) begin errors++;
            $display("FAIL dwr_release: got w=%b r=%b cnt=%0d want 0 0 4", m_write, m_read, d_count); end
        tick();
    endtask

    task automatic test_rw_both();
        int n;
        d_read = 1'b1; d_write = 1'b1; d_address = 6'h07;
        tick();
        checks++; if (m_write !== 1'b1 || m_read !== 1'b0) begin errors++;
            $display("FAIL rw_both: got w=%b r=%b want 1 0", m_write, m_read); end
        wait_bw(1'b1, n);
        tick(); d_read = 1'b0; d_write = 1'b0;
        checks++; if (d_count !== 8'd5) begin errors++;
            $display("FAIL rw_cnt: got %0d want 5", d_count); end
        tick();
    endtask

    task automatic test_drop();
        mem_lat = 4;
        d_read = 1'b1; d_address = 6'h09;
        tick(); tick(); tick();
        d_read = 1'b0;
        tick();
        checks++; if (m_read !== 1'b0 || d_count !== 8'd5) begin errors++;
            $display("FAIL drop_release: got mr=%b cnt=%0d want 0 5", m_read, d_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        mem_lat = 6;
        i_read = 1'b1; i_address = 6'h05;
        tick();
        checks++; if (m_read !== 1'b1) begin errors++;
            $display("FAIL rmid_grant: got %b want 1", m_read); end
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        checks++; if (m_read !== 1'b0 || m_address !== 6'd0) begin errors++;
            $display("FAIL rmid_strobe: got r=%b addr=%h want 0 00", m_read, m_address); end
        checks++; if (i_count !== 8'd0 || d_count !== 8'd0) begin errors++;
            $display("FAIL rmid_cnt: got %0d %0d want 0 0", i_count, d_count); end
        checks++; if (i_busywait !== 1'b1) begin errors++;
            $display("FAIL rmid_busy: got %b want 1", i_busywait); end
        @(posedge clock); #1;
        reset = 1'b1;
        d_read = 1'b1; d_address = 6'h02;
        tick();
        checks++; if (m_read !== 1'b1 || m_address !== 6'h02) begin errors++;
            $display("FAIL rmid_D_first: got r=%b addr=%h want 1 02", m_read, m_address); end
        wait_bw(1'b1, n);
        checks++; if (n != 7) begin errors++;
            $display("FAIL rmid_latency: got %0d want 7", n); end
        tick(); d_read = 1'b0; i_read = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        int comps = 0;
        int cyc = 0;
        mem_lat = 1;
        i_read = 1'b1; i_address = 6'h11;
        while (comps < 256 && cyc < 5000) begin
            tick(); cyc++;
            if (i_busywait == 1'b0) comps++;
        end
        checks++; if (comps != 256) begin errors++;
            $display("FAIL sat_timeout: got %0d completions want 256", comps); end
        checks++; if (i_count !== 8'hFF) begin errors++;
            $display("FAIL sat_reach: got %h want ff", i_count); end
        tick(); i_read = 1'b0;
        checks++; if (i_count !== 8'hFF) begin errors++;
            $display("FAIL sat_hold: got %h want ff", i_count); end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_i_read();
        test_d_write();
        test_rw_both();
        test_drop();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-port arbiter that shares one 128-bit-block main memory between the instruction cache and the data cache. It sits between the two caches and the memory model and sequences one whole block transaction (read or write-back) at a time. Simultaneous requests are resolved round-robin. Each cache sees the same busywait handshake it would see from a dedicated memory.

## Interface
Parameters:
- ADDR_W, default 6: block address width.
- BLK_W, default 128: block data width.
- CNT_W, default 16: width of the transaction statistics counters.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- i_read  in  1  instruction-cache block read request.
- i_address  in  ADDR_W  instruction-cache block address.
- i_readdata  out  BLK_W  block returned to the instruction cache.
- i_busywait  out  1  stall to the instruction cache.
- d_read  in  1  data-cache block read request.
- d_write  in  1  data-cache block write-back request.
- d_address  in  ADDR_W  data-cache block address.
- d_writedata  in  BLK_W  write-back block.
- d_readdata  out  BLK_W  block returned to the data cache.
- d_busywait  out  1  stall to the data cache.
- m_read, m_write  out  1  memory request strobes.
- m_address  out  ADDR_W  memory block address.
- m_writedata  out  BLK_W  memory write data.
- m_readdata  in  BLK_W  memory read data.
- m_busywait  in  1  memory busy.
- i_count, d_count  out  CNT_W  completed transactions per port; saturating.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE. The state, the `started` flag, the `last` flag, and both counters are registered.
- IDLE, no request: stay in IDLE.
- IDLE, only the I request (i_read) is active: go to GRANT_I.
- IDLE, only the D request (d_read|d_write) is active: go to GRANT_D.
- IDLE, both requests active: grant the port not served last (`last` holds 0=I, 1=D). Reset value of `last` is I, so D wins the first tie.
- GRANT_x drives the memory port from requester x:
  - GRANT_I: m_read=1, m_address=i_address.
  - GRANT_D: m_write=d_write, m_read=d_read&~d_write (write wins if both are set), m_address=d_address, m_writedata=d_writedata.
- In every other state, m_read, m_write, m_address, and m_writedata are 0.
- `started` is set on the first edge in GRANT_x where m_busywait=1. It is cleared on leaving GRANT_x.
- Completion condition: GRANT_x && started && !m_busywait.
- On the completion edge:
  - go to RELEASE;
  - set `last`=x;
  - increment x_count, saturating at all-ones.
- RELEASE lasts exactly one cycle with the memory strobes low, then the FSM goes to IDLE.
- i_readdata/d_readdata = m_readdata, gated to 0 unless the corresponding port is granted.
- Busywait outputs (combinational):
  - i_busywait = i_read & ~(state==GRANT_I & completion).
  - d_busywait = (d_read|d_write) & ~(state==GRANT_D & completion).
- If the granted requester drops its request before completion, the FSM goes to RELEASE without incrementing its counter or updating `last`.
- Reset, asynchronous and at any time including mid-transaction:
  - state=IDLE, started=0, last=I, counters=0;
  - memory strobes drop immediately;
  - all outputs are 0 except busywaits, which follow their requests.

## Timing
- Request sampled at edge N in IDLE: grant and memory strobe from edge N+1.
- For a memory busy for B cycles (B≥1) after it sees the strobe, completion occurs B+1 cycles after the grant.
- Requester busywait falls in the completion cycle. The requester latches readdata and drops its request at the completion edge.
- Minimum spacing between two grants: grant, memory cycles, RELEASE, IDLE. This gives back-to-back grants with at least 2 idle-strobe cycles between transactions.
- A request arriving during GRANT_x or RELEASE waits. Its busywait stays 1.

## Test plan
- Single I read at address 6'h05, memory busy 4 cycles, data 128'hA5…: response is m_read=1 with m_address=5 one cycle after the request; i_busywait falls in the completion cycle; i_readdata matches; i_count=1; d_busywait never asserted.
- D write-back at address 6'h3F with data 128'h1234…: response is m_write=1, m_read=0, m_writedata passed through; d_count=1; RELEASE cycle shows both strobes 0.
- I and D requests asserted on the same edge after reset: D granted first (d_count=1 while i_busywait=1), then I. Repeat the tie: order alternates D, I, I, D according to `last`.
- d_read=d_write=1 simultaneously: only m_write=1 is issued.
- Reset pulled low during GRANT_I with memory busy: m_read=0 within the same cycle; counters=0; after release, a new D request is granted first.
- 65 535 I reads followed by one more: i_count saturates at 16'hFFFF.
